// File: rtl/t05_sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : t05_sram_arb_pkg
// Description : Shared state encoding and SRAM command codes for the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package t05_sram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        SETTLE = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [1:0] MEM_READ  = 2'd0;
    localparam logic [1:0] MEM_WRITE = 2'd1;
    localparam logic [1:0] MEM_IDLE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/t05_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : t05_rr_pick
// Description : Combinational round-robin picker; search starts after 'last'.
// Revision    : 1.0 - initial release
// ============================================================================
module t05_rr_pick
    import t05_sram_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    int cand;

    // Walk offsets from farthest to nearest so the nearest asserted bit wins.
    always_comb begin
        valid = 1'b0;
        idx   = last;
        cand  = 0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = int'(last) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (req[cand]) begin
                valid = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/t05_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : t05_sram_arbiter
// Description : Round-robin arbiter sharing one SRAM port among NREQ stages.
//               Optional abort of stuck accesses: T05_SRAM_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module t05_sram_arbiter
    import t05_sram_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               en,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    we_i,
    input  logic [NREQ*AW-1:0] addr_i,
    input  logic [NREQ*DW-1:0] wdata_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    ack_o,
    output logic [NREQ-1:0]    err_o,
    output logic [DW-1:0]      rdata_o,
    output logic [1:0]         mem_wr_r_en_o,
    output logic [AW-1:0]      mem_addr_o,
    output logic [DW-1:0]      mem_wdata_o,
    input  logic [DW-1:0]      mem_rdata_i,
    input  logic               mem_busy_i
);

    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
        $fatal(1, "t05_sram_arbiter: NREQ must be 2..8 and TIMEOUT 1..255");
    end

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   last_grant;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   rdata_q;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            grant_now;
    logic            active;
    logic            to_hit;
    logic [NREQ-1:0] idx_onehot;

    t05_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req   (req_i),
        .last  (last_grant),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick_idx == IW'(k)) begin
                sel_we    = we_i[k];
                sel_addr  = addr_i[k*AW +: AW];
                sel_wdata = wdata_i[k*DW +: DW];
            end
        end
    end

    assign grant_now = (state == IDLE) && en && pick_valid;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_now) state_nxt = ISSUE;
            ISSUE:   state_nxt = SETTLE;
            SETTLE:  state_nxt = WAIT;
            WAIT:    if (!mem_busy_i || to_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            idx_q      <= '0;
            last_grant <= IW'(NREQ - 1);
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state <= state_nxt;
            if (grant_now) begin
                idx_q   <= pick_idx;
                we_q    <= sel_we;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
            if (state == DONE) begin
                last_grant <= idx_q;
            end
            if (state == WAIT) begin
                if (to_hit) begin
                    rdata_q <= '0;
                end else if (!mem_busy_i && !we_q) begin
                    rdata_q <= mem_rdata_i;
                end
            end
        end
    end

`ifdef T05_SRAM_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] to_cnt;
    logic       to_flag;

    assign to_hit = (state == WAIT) && mem_busy_i && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else if (state == SETTLE) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else if (state == WAIT && mem_busy_i) begin
            to_cnt <= to_cnt + 8'd1;
            if (to_hit) begin
                to_flag <= 1'b1;
            end
        end
    end

    assign err_o = (state == DONE && to_flag) ? idx_onehot : '0;
`else
    assign to_hit = 1'b0;
    assign err_o  = '0;
`endif

    // Port outputs decode straight from state so reset clears them instantly.
    assign active        = (state != IDLE);
    assign idx_onehot    = NREQ'(1) << idx_q;
    assign gnt_o         = active ? idx_onehot : '0;
    assign ack_o         = (state == DONE) ? idx_onehot : '0;
    assign rdata_o       = rdata_q;
    assign mem_wr_r_en_o = (state == ISSUE) ? (we_q ? MEM_WRITE : MEM_READ) : MEM_IDLE;
    assign mem_addr_o    = active ? addr_q : '0;
    assign mem_wdata_o   = active ? wdata_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_t05_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_t05_sram_arbiter
// Description : Directed self-checking bench for t05_sram_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_t05_sram_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic               clk = 1'b0;
    logic               nrst;
    logic               en;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic [NREQ-1:0]    err;
    logic [DW-1:0]      rdata;
    logic [1:0]         mem_cmd;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;
    logic               mem_busy;

    int n_chk  = 0;
    int n_fail = 0;

    t05_sram_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .en            (en),
        .req_i         (req),
        .we_i          (we),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .gnt_o         (gnt),
        .ack_o         (ack),
        .err_o         (err),
        .rdata_o       (rdata),
        .mem_wr_r_en_o (mem_cmd),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata),
        .mem_busy_i    (mem_busy)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst      = 1'b0;
        en        = 1'b0;
        req       = '0;
        we        = '0;
        addr      = '0;
        wdata     = '0;
        mem_rdata = '0;
        mem_busy  = 1'b0;
        #1;
        chk_eq("rst_gnt",   64'(gnt),       64'h0);
        chk_eq("rst_ack",   64'(ack),       64'h0);
        chk_eq("rst_err",   64'(err),       64'h0);
        chk_eq("rst_rdata", 64'(rdata),     64'h0);
        chk_eq("rst_cmd",   64'(mem_cmd),   64'h3);
        chk_eq("rst_addr",  64'(mem_addr),  64'h0);
        chk_eq("rst_wdata", 64'(mem_wdata), 64'h0);
        tick();
        tick();
        nrst = 1'b1;
        tick();

        // Single read from requester 1, busy low throughout
        en               = 1'b1;
        req              = 4'b0010;
        addr[1*AW +: AW] = 32'h40;
        mem_rdata        = 32'h0000_0007;
        chk_eq("rd_c0_gnt", 64'(gnt), 64'h0);
        tick();
        chk_eq("rd_c1_gnt",  64'(gnt),      64'h2);
        chk_eq("rd_c1_cmd",  64'(mem_cmd),  64'h0);
        chk_eq("rd_c1_addr", 64'(mem_addr), 64'h40);
        tick();
        chk_eq("rd_c2_cmd", 64'(mem_cmd), 64'h3);
        chk_eq("rd_c2_ack", 64'(ack),     64'h0);
        tick();
        chk_eq("rd_c3_ack", 64'(ack), 64'h0);
        tick();
        chk_eq("rd_c4_ack",   64'(ack),   64'h2);
        chk_eq("rd_c4_err",   64'(err),   64'h0);
        chk_eq("rd_c4_rdata", 64'(rdata), 64'h7);
        req       = '0;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        chk_eq("rd_c5_ack",   64'(ack),      64'h0);
        chk_eq("rd_c5_gnt",   64'(gnt),      64'h0);
        chk_eq("rd_c5_rdata", 64'(rdata),    64'h7);
        chk_eq("rd_c5_addr",  64'(mem_addr), 64'h0);

        // Write from requester 0 with three busy cycles in WAIT
        req               = 4'b0001;
        we                = 4'b0001;
        wdata[0*DW +: DW] = 32'h8;
        addr[0*AW +: AW]  = 32'h123;
        tick();
        chk_eq("wr_c1_gnt",   64'(gnt),       64'h1);
        chk_eq("wr_c1_cmd",   64'(mem_cmd),   64'h1);
        chk_eq("wr_c1_wdata", 64'(mem_wdata), 64'h8);
        tick();
        chk_eq("wr_c2_cmd", 64'(mem_cmd), 64'h3);
        mem_busy = 1'b1;
        for (int c = 3; c <= 6; c++) begin
            tick();
            if (c == 6) mem_busy = 1'b0;
            chk_eq("wr_wait_ack",   64'(ack),       64'h0);
            chk_eq("wr_wait_wdata", 64'(mem_wdata), 64'h8);
        end
        tick();
        chk_eq("wr_c7_ack",   64'(ack),       64'h1);
        chk_eq("wr_c7_wdata", 64'(mem_wdata), 64'h8);
        chk_eq("wr_c7_rdata", 64'(rdata),     64'h7);
        req = '0;
        we  = '0;
        tick();

        // Reset pulse while requester 2 is waiting on a busy SRAM
        req = 4'b0100;
        tick();
        chk_eq("nr_c1_gnt", 64'(gnt), 64'h4);
        tick();
        mem_busy = 1'b1;
        tick();
        tick();
        nrst = 1'b0;
        #1;
        chk_eq("nr_gnt",   64'(gnt),       64'h0);
        chk_eq("nr_ack",   64'(ack),       64'h0);
        chk_eq("nr_cmd",   64'(mem_cmd),   64'h3);
        chk_eq("nr_rdata", 64'(rdata),     64'h0);
        chk_eq("nr_addr",  64'(mem_addr),  64'h0);
        chk_eq("nr_wdata", 64'(mem_wdata), 64'h0);
        mem_busy = 1'b0;
        req      = 4'b1111;
        tick();
        chk_eq("nr_hold_ack", 64'(ack), 64'h0);
        nrst = 1'b1;

        // Contention: all held high, grants rotate 0,1,2,3,0 every 5 cycles
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (c % 5 == 4)
                chk_eq("rr_ack", 64'(ack), 64'(4'b0001 << ((c / 5) % 4)));
            else
                chk_eq("rr_ack", 64'(ack), 64'h0);
            if (c % 5 == 1)
                chk_eq("rr_gnt", 64'(gnt), 64'(4'b0001 << ((c / 5) % 4)));
        end
        req = '0;
        tick();

        // Enable dropped mid-WAIT: access completes, no new grant while low
        req = 4'b1000;
        tick();
        chk_eq("en_c1_gnt", 64'(gnt), 64'h8);
        tick();
        mem_busy = 1'b1;
        tick();
        en  = 1'b0;
        req = 4'b1010;
        tick();
        mem_busy = 1'b0;
        tick();
        chk_eq("en_c5_ack", 64'(ack), 64'h8);
        req = 4'b0010;
        tick();
        chk_eq("en_c6_gnt", 64'(gnt), 64'h0);
        tick();
        chk_eq("en_c7_gnt", 64'(gnt), 64'h0);
        en = 1'b1;
        tick();
        tick();
        chk_eq("en_c9_gnt", 64'(gnt), 64'h2);
        begin
            int  budget;
            logic seen;
            budget = 0;
            seen   = 1'b0;
            while (!seen && budget < 10) begin
                tick();
                budget++;
                if (ack == 4'b0010) seen = 1'b1;
            end
            chk_eq("en_ack_seen", 64'(seen), 64'h1);
        end
        req = '0;
        tick();

`ifdef T05_SRAM_ARB_TIMEOUT_EN
        // Busy stuck high: abort after 4 WAIT cycles with err and zero data
        req       = 4'b0001;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        tick();
        mem_busy = 1'b1;
        for (int c = 3; c <= 6; c++) begin
            tick();
            chk_eq("to_wait_ack", 64'(ack), 64'h0);
        end
        tick();
        chk_eq("to_c7_ack",   64'(ack),   64'h1);
        chk_eq("to_c7_err",   64'(err),   64'h1);
        chk_eq("to_c7_rdata", 64'(rdata), 64'h0);
        req = '0;
        tick();
        chk_eq("to_c8_err", 64'(err), 64'h0);
        mem_busy = 1'b0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
